// File: rtl/sine_voice_pkg.sv
// Shared definitions for the sine voice scheduler.
//   state_t    : sweep FSM states
//   LUT_IDX_W  : width of the shared sine lookup index
//   LUT_OUT_W  : width of the shared sine lookup result
//   mix_width  : minimum mix width for n voices (no-overflow sum)
package sine_voice_pkg;

    typedef enum logic [1:0] {IDLE, ADDR, READ, DONE} state_t;

    localparam int LUT_IDX_W = 8;
    localparam int LUT_OUT_W = 11;

    function automatic int mix_width(input int n);
        return LUT_OUT_W + $clog2(n);
    endfunction

endpackage

// File: rtl/sine_phase_bank.sv
// Per-voice phase accumulator register file.
//   clk, rst   : clock, async active-high reset (all phases -> 0)
//   rd_idx     : voice to read; rd_phase is combinational from it
//   wr_en      : write strobe for voice wr_idx
//   wr_add     : 1 = phase += that voice's tune word (wraps), 0 = phase cleared
//   tune_word  : packed per-voice increments, voice i at [i*PHASE_W +: PHASE_W]
module sine_phase_bank #(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 16,
    parameter int VID_W      = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [VID_W-1:0]              rd_idx,
    output logic [PHASE_W-1:0]            rd_phase,
    input  logic                          wr_en,
    input  logic [VID_W-1:0]              wr_idx,
    input  logic                          wr_add,
    input  logic [NUM_VOICES*PHASE_W-1:0] tune_word
);

    logic [NUM_VOICES-1:0][PHASE_W-1:0] phase;

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_lane
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                phase[i] <= '0;
            else if (wr_en && wr_idx == VID_W'(i))
                phase[i] <= wr_add ? phase[i] + tune_word[i*PHASE_W +: PHASE_W] : '0;
        end
    end

    // Compare-based mux so an index past NUM_VOICES-1 reads 0 rather than X.
    always_comb begin
        rd_phase = '0;
        for (int i = 0; i < NUM_VOICES; i++)
            if (rd_idx == VID_W'(i)) rd_phase = phase[i];
    end

endmodule

// File: rtl/sine_voice_scheduler.sv
// Time-multiplexes one combinational sine lookup across NUM_VOICES voices.
// Each sample_tick starts a sweep: per voice an ADDR cycle (index presented)
// and a READ cycle (result accumulated, phase advanced), then a DONE cycle
// that flags the new mix.
//   clk, rst     : clock, async active-high reset
//   sample_tick  : request a new mix sample (ignored + overrun outside IDLE)
//   voice_en     : per-voice enable; disabled voices add nothing, phase -> 0
//   tune_word    : packed per-voice phase increments
//   lut_period   : index to the shared lookup; lut_sine is its result
//   mix/mix_valid: mix sample and its one-cycle strobe
//   busy         : sweep in progress
//   overrun      : sticky, a tick arrived while busy
// Optional: define SINE_VOICE_SCHED_TAP_EN for per-voice tap outputs
//   voice_sample / voice_id / voice_valid, valid in READ of enabled voices.
module sine_voice_scheduler
    import sine_voice_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 16,
    parameter int MIX_W      = 13
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sample_tick,
    input  logic [NUM_VOICES-1:0]         voice_en,
    input  logic [NUM_VOICES*PHASE_W-1:0] tune_word,
    output logic [LUT_IDX_W-1:0]          lut_period,
    input  logic [LUT_OUT_W-1:0]          lut_sine,
    output logic [MIX_W-1:0]              mix,
    output logic                          mix_valid,
    output logic                          busy,
    output logic                          overrun
`ifdef SINE_VOICE_SCHED_TAP_EN
    ,
    output logic [LUT_OUT_W-1:0]          voice_sample,
    output logic [3:0]                    voice_id,
    output logic                          voice_valid
`endif
);

    localparam int VID_W = $clog2(NUM_VOICES);

    if (MIX_W < mix_width(NUM_VOICES)) begin : g_bad_mix_w
        $error("MIX_W too narrow for NUM_VOICES");
    end
    if (PHASE_W < LUT_IDX_W) begin : g_bad_phase_w
        $error("PHASE_W must be at least LUT_IDX_W");
    end

    state_t               state_q, state_d;
    logic [VID_W-1:0]     voice_q;
    logic [MIX_W-1:0]     acc_q, acc_sum;
    logic [MIX_W-1:0]     mix_q;
    logic [LUT_IDX_W-1:0] period_q;
    logic                 overrun_q;

    logic                 voice_on, last_voice;
    logic [VID_W-1:0]     rd_idx;
    logic [PHASE_W-1:0]   rd_phase;

    assign voice_on   = voice_en[voice_q];
    assign last_voice = (voice_q == VID_W'(NUM_VOICES - 1));
    assign acc_sum    = acc_q + (voice_on ? MIX_W'(lut_sine) : '0);

    // Read port looks one voice ahead so the index is registered on the edge
    // entering ADDR and is already visible during that ADDR cycle.
    assign rd_idx = (state_q == IDLE) ? '0 : voice_q + VID_W'(1);

    sine_phase_bank #(
        .NUM_VOICES (NUM_VOICES),
        .PHASE_W    (PHASE_W),
        .VID_W      (VID_W)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (rd_idx),
        .rd_phase  (rd_phase),
        .wr_en     (state_q == READ),
        .wr_idx    (voice_q),
        .wr_add    (voice_on),
        .tune_word (tune_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sample_tick) state_d = ADDR;
            ADDR:    state_d = READ;
            READ:    state_d = last_voice ? DONE : ADDR;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            voice_q   <= '0;
            acc_q     <= '0;
            mix_q     <= '0;
            period_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (sample_tick && state_q != IDLE) overrun_q <= 1'b1;
            case (state_q)
                IDLE: if (sample_tick) begin
                    voice_q  <= '0;
                    acc_q    <= '0;
                    period_q <= rd_phase[PHASE_W-1 -: LUT_IDX_W];
                end
                READ: begin
                    acc_q <= acc_sum;
                    // Mix is loaded on the edge into DONE so it is already
                    // valid while mix_valid is high.
                    if (last_voice) begin
                        mix_q <= acc_sum;
                    end else begin
                        voice_q  <= voice_q + VID_W'(1);
                        period_q <= rd_phase[PHASE_W-1 -: LUT_IDX_W];
                    end
                end
                default: ;
            endcase
        end
    end

    assign lut_period = period_q;
    assign mix        = mix_q;
    assign mix_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign overrun    = overrun_q;

`ifdef SINE_VOICE_SCHED_TAP_EN
    assign voice_valid  = (state_q == READ) && voice_on;
    assign voice_sample = voice_valid ? lut_sine : '0;
    assign voice_id     = voice_valid ? 4'(voice_q) : 4'd0;
`endif

endmodule
